// File: rtl/cube_scan_ctrl.sv
// Row-group scan controller for a 16-group LED cube: fetches one column word per
// group from a double-banked frame RAM, lights it for DWELL cycles, blanks, advances.
module cube_scan_ctrl #(
  parameter int unsigned DWELL = 1000,
  parameter int unsigned BLANK = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        frame_req,
  output logic        frame_ack,
  output logic        buf_sel,
  output logic        rd_en,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [31:0] col_data,
  output logic [3:0]  sel,
  output logic        sel_valid,
  output logic        frame_start
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SHOW,
    ST_BLANK
  } state_t;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [3:0]  group, group_d;
  logic        buf_sel_d, frame_ack_d;
  logic        rd_en_d, sel_valid_d, frame_start_d, load;
  logic [4:0]  rd_addr_d;
  logic [31:0] col_data_d;
  logic [3:0]  sel_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d     = state;
    cnt_d       = cnt;
    group_d     = group;
    buf_sel_d   = buf_sel;
    frame_ack_d = 1'b0;

    // Stopping wins over everything, including a swap that would fall on this cycle.
    if (state != ST_IDLE && !enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      group_d = '0;
    end else begin
      case (state)
        ST_IDLE:  if (enable) state_d = ST_FETCH;
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
        ST_SHOW: begin
          if (cnt == DWELL_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 16'd1;
          end
        end
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_d = ST_FETCH;
            cnt_d   = '0;
            group_d = group + 4'd1;
            // Bank swap only at the frame boundary so a frame is never mixed.
            if (group == 4'd15 && frame_req) begin
              buf_sel_d   = ~buf_sel;
              frame_ack_d = 1'b1;
            end
          end else begin
            cnt_d = cnt + 16'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are decoded from the state being entered so they register in step with it.
    rd_en_d       = (state_d == ST_FETCH);
    rd_addr_d     = rd_en_d ? {buf_sel_d, group_d} : rd_addr;
    sel_valid_d   = (state_d == ST_SHOW);
    frame_start_d = (state_d == ST_LOAD) && (group_d == 4'd0);
    load          = (state == ST_LOAD) && (state_d == ST_SHOW);
    col_data_d    = load ? rd_data : col_data;
    sel_d         = load ? group : sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      group       <= '0;
      buf_sel     <= 1'b0;
      frame_ack   <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      col_data    <= '0;
      sel         <= '0;
      sel_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of order.
      state       <= state_d;
      cnt         <= cnt_d;
      group       <= group_d;
      buf_sel     <= buf_sel_d;
      frame_ack   <= frame_ack_d;
      rd_en       <= rd_en_d;
      rd_addr     <= rd_addr_d;
      col_data    <= col_data_d;
      sel         <= sel_d;
      sel_valid   <= sel_valid_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_cube_scan_ctrl.sv
// Directed bench for cube_scan_ctrl with DWELL=4, BLANK=2 (group period 8, frame 128).
module tb_cube_scan_ctrl;

  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int PER   = DWELL + BLANK + 2;
  localparam int FRAME = 16 * PER;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        frame_req = 1'b0;
  logic        frame_ack, buf_sel, rd_en, sel_valid, frame_start;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data = '0;
  logic [31:0] col_data;
  logic [3:0]  sel;

  int n_checks = 0;
  int n_pass   = 0;

  cube_scan_ctrl #(.DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .frame_req  (frame_req),
    .frame_ack  (frame_ack),
    .buf_sel    (buf_sel),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .col_data   (col_data),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [4:0] a);
    return {8'hA5, 3'b000, a, 11'h000, ~a};
  endfunction

  // Synchronous frame RAM: data valid the cycle after rd_en.
  always @(posedge clk) if (rd_en) rd_data <= ram_word(rd_addr);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
  endtask

  // Expected outputs r cycles after the IDLE cycle that sampled enable=1.
  task automatic check_cycle(input int r, input logic bank, input logic ack);
    int p, g;
    p = (r - 1) % PER;
    g = ((r - 1) / PER) % 16;
    check("rd_en", 32'(rd_en), 32'(p == 0));
    if (p == 0) check("rd_addr", 32'(rd_addr), 32'({bank, 4'(g)}));
    check("frame_start", 32'(frame_start), 32'(p == 1 && g == 0));
    check("sel_valid", 32'(sel_valid), 32'(p >= 2 && p <= 1 + DWELL));
    if (p >= 2 && p <= 1 + DWELL) begin
      check("sel", 32'(sel), 32'(g));
      check("col_data", col_data, ram_word({bank, 4'(g)}));
    end
    check("buf_sel", 32'(buf_sel), 32'(bank));
    check("frame_ack", 32'(frame_ack), 32'(ack));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sel_valid"}, 32'(sel_valid), 32'd0);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_col_data"}, col_data, 32'd0);
    check({tag, "_sel"}, 32'(sel), 32'd0);
    check({tag, "_buf_sel"}, 32'(buf_sel), 32'd0);
    check({tag, "_frame_ack"}, 32'(frame_ack), 32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
  endtask

  function automatic logic req_for(input int c);
    return (c >= 297 && c <= 512) || (c >= 530 && c <= 640);
  endfunction

  // Lit group must be stable: sel and col_data may not move while sel_valid stays high.
  logic        prev_valid = 1'b0;
  logic [3:0]  prev_sel = '0;
  logic [31:0] prev_col = '0;
  always @(negedge clk) begin
    if (prev_valid && sel_valid) begin
      check("stable_sel", 32'(sel), 32'(prev_sel));
      check("stable_col", col_data, prev_col);
    end
    prev_valid = sel_valid;
    prev_sel   = sel;
    prev_col   = col_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_bank, ack, req_prev;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Release and enable; this negedge lies in cycle 0.
    rst_n  = 1'b1;
    enable = 1'b1;
    exp_bank = 1'b0;
    req_prev = 1'b0;
    for (int c = 1; c <= 716; c++) begin
      @(negedge clk);
      ack = (c > 1) && (((c - 1) % FRAME) == 0) && req_prev;
      if (ack) exp_bank = ~exp_bank;
      check_cycle(c, exp_bank, ack);
      frame_req = req_for(c);
      req_prev  = frame_req;
    end

    // Cycle 716 is the second SHOW cycle of group 9, bank 1: stop the scan.
    enable = 1'b0;
    @(negedge clk);
    check("stop_sel_valid", 32'(sel_valid), 32'd0);
    check("stop_rd_en", 32'(rd_en), 32'd0);
    check("stop_sel", 32'(sel), 32'd9);
    check("stop_col_data", col_data, ram_word(5'h19));
    check("stop_buf_sel", 32'(buf_sel), 32'd1);
    check("stop_frame_ack", 32'(frame_ack), 32'd0);
    repeat (2) @(negedge clk);
    check("idle_sel_valid", 32'(sel_valid), 32'd0);
    check("idle_rd_en", 32'(rd_en), 32'd0);

    // Re-enable: restart at group 0 of bank 1.
    enable = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check_cycle(c, 1'b1, 1'b0);
    end

    // Cycle 20 is mid-SHOW of group 2: reset must clear outputs without a clock edge.
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    repeat (2) @(negedge clk);
    check_all_zero("rst_hold");

    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check_cycle(c, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cube_scan_ctrl.md
CUBE_SCAN_CTRL -- requirements
Module: cube_scan_ctrl

Interface
REQ-001 Parameters: DWELL, default 1000, SHOW cycles per row group (1..65535); BLANK, default 16, blanking cycles per row group (1..65535).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  scan run/stop, level.
REQ-005 frame_req  input  1  producer has a new frame in the back bank, level, held until frame_ack.
REQ-006 frame_ack  output  1  one-cycle pulse, bank swap accepted.
REQ-007 buf_sel  output  1  bank currently displayed.
REQ-008 rd_en  output  1  frame-RAM read strobe.
REQ-009 rd_addr  output  5  frame-RAM address {buf_sel, group[3:0]}.
REQ-010 rd_data  input  32  frame-RAM data, valid exactly 1 cycle after rd_en.
REQ-011 col_data  output  32  registered column drive for the current group.
REQ-012 sel  output  4  row-group index to the 4-to-16 decoder.
REQ-013 sel_valid  output  1  decoder output enable; high only while a group is lit.
REQ-014 frame_start  output  1  one-cycle pulse when group 0 is loaded.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, LOAD, SHOW, BLANK; all outputs registered.
REQ-016 IDLE: enable=1 -> FETCH; else stay; sel_valid=0, rd_en=0.
REQ-017 FETCH (1 cycle): rd_en=1, rd_addr={buf_sel, group} -> LOAD.
REQ-018 LOAD (1 cycle): col_data<=rd_data, sel<=group; frame_start=1 when group=0 -> SHOW.
REQ-019 SHOW: sel_valid=1 for exactly DWELL cycles, then -> BLANK.
REQ-020 BLANK: sel_valid=0 for exactly BLANK cycles; on last cycle group<=group+1 (mod 16) -> FETCH.
REQ-021 sel_valid SHALL be 0 in IDLE, FETCH, LOAD and BLANK; col_data and sel SHALL change only in LOAD (never while sel_valid=1).
REQ-022 Group period = DWELL+BLANK+2 cycles; frame period = 16*(DWELL+BLANK+2) cycles.
REQ-023 First sel_valid=1 occurs 3 cycles after the IDLE cycle that samples enable=1.
REQ-024 Frame boundary = last BLANK cycle of group 15 (group wraps 15->0); if frame_req=1 in that cycle, buf_sel toggles and frame_ack pulses in the next cycle; the next FETCH uses the new bank.
REQ-025 frame_req asserted mid-frame SHALL NOT change buf_sel before the frame boundary; no partial-frame display from the new bank.
REQ-026 frame_req held high after frame_ack SHALL cause another swap at the following boundary (producer drops req after ack).
REQ-027 enable=0 sampled in any non-IDLE state -> IDLE next cycle; sel_valid=0, group<=0, dwell/blank counter<=0; buf_sel, col_data, sel retained; no frame_ack issued.
REQ-028 enable re-asserted restarts at group 0 of the current bank per REQ-023.
REQ-029 Counters 16 bits unsigned; group 4 bits, wrap silent.

Reset
REQ-030 rst_n=0 SHALL asynchronously force: state IDLE, group 0, counters 0, buf_sel 0, col_data 0, sel 0, sel_valid 0, rd_en 0, rd_addr 0, frame_ack 0, frame_start 0.
REQ-031 Reset mid-SHOW SHALL drop sel_valid in the same cycle reset asserts; deassertion synchronous-release safe (first action on the following edge).

Verification (DWELL=4, BLANK=2, period 8, frame 128)
REQ-032 Reset then enable=1 at cycle 0 -> rd_en cycle 1, addr 0x00; frame_start cycle 2; sel_valid cycles 3-6; sel=0.
REQ-033 Free run 2 frames -> sel sequence 0..15,0..; rd_addr 0x00..0x0F; frame_start every 128 cycles; sel_valid duty 4/8.
REQ-034 frame_req=1 in group 5 -> buf_sel stays 0 until boundary; frame_ack one pulse after group-15 BLANK; next rd_addr 0x10.
REQ-035 enable=0 during SHOW of group 9 -> sel_valid 0 next cycle, IDLE; re-enable -> rd_addr {buf_sel,0}, no frame_ack.
REQ-036 rst_n low mid-SHOW with buf_sel=1 -> all outputs 0 immediately, buf_sel=0.
REQ-037 Checker: sel and col_data never change while sel_valid=1.
